// File: rtl/lru_pkg.sv
// Shared types and pseudo-LRU tree helpers for the 4-way LRU update controller.
// Tree bits are {b2, b1, b0}: b0 picks the half, b1/b2 pick the way within it.
package lru_pkg;
  typedef logic [1:0] way_t;
  typedef logic [2:0] plru_t;

  localparam int NUM_WAYS = 4;

  function automatic way_t plru_victim(input plru_t b);
    if (!b[0]) plru_victim = b[1] ? 2'd1 : 2'd0;
    else       plru_victim = b[2] ? 2'd3 : 2'd2;
  endfunction

  // Point the tree away from the way just touched; the other half's bit is kept.
  function automatic plru_t plru_touch(input plru_t b, input way_t w);
    plru_touch = b;
    case (w)
      2'd0: begin plru_touch[0] = 1'b1; plru_touch[1] = 1'b1; end
      2'd1: begin plru_touch[0] = 1'b1; plru_touch[1] = 1'b0; end
      2'd2: begin plru_touch[0] = 1'b0; plru_touch[2] = 1'b1; end
      default: begin plru_touch[0] = 1'b0; plru_touch[2] = 1'b0; end
    endcase
  endfunction
endpackage

// File: rtl/plru_next.sv
// Combinational next-state for one pseudo-LRU tree: picks the touched way
// (hit way or victim) and returns the updated tree bits.
module plru_next
  import lru_pkg::*;
(
  input  plru_t cur_bits,
  input  logic  hit,
  input  way_t  hit_way,
  output way_t  way,
  output plru_t new_bits
);
  way_t victim;

  always_comb begin
    victim   = plru_victim(cur_bits);
    way      = hit ? hit_way : victim;
    new_bits = plru_touch(cur_bits, way);
  end
endmodule

// File: rtl/lru_update_ctrl.sv
// Read-modify-write controller for a 4-way pseudo-LRU state array.
// Optional LRU_FWD_EN: forward the retiring write to a same-set request instead of stalling.
module lru_update_ctrl
  import lru_pkg::*;
#(
  parameter int S_INDEX = 4,
  parameter int WIDTH   = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [S_INDEX-1:0] req_set,
  input  logic               req_hit,
  input  logic [1:0]         req_way,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [1:0]         resp_way,
  output logic               lru_csb0,
  output logic               lru_web0,
  output logic [S_INDEX-1:0] lru_addr0,
  input  logic [WIDTH-1:0]   lru_dout0,
  output logic               lru_csb1,
  output logic               lru_web1,
  output logic [S_INDEX-1:0] lru_addr1,
  output logic [WIDTH-1:0]   lru_din1
);
  if (WIDTH != 3) begin : g_width_chk
    $error("lru_update_ctrl: only WIDTH=3 (4 ways) is supported");
  end

  logic               s1_valid_q, s1_valid_d;
  logic [S_INDEX-1:0] s1_set_q,   s1_set_d;
  way_t               s1_way_q,   s1_way_d;
  plru_t              s1_bits_q,  s1_bits_d;

  logic  fire, accept, same_set, hazard;
  plru_t cur_bits, new_bits;
  way_t  s0_way;

  assign fire     = s1_valid_q & resp_ready;
  assign same_set = s1_valid_q & (req_set == s1_set_q);

`ifdef LRU_FWD_EN
  // A same-set request can only be accepted on the fire cycle, so s1_bits
  // is exactly the value being written to the array at this edge.
  assign hazard   = 1'b0;
  assign cur_bits = same_set ? s1_bits_q : plru_t'(lru_dout0);
`else
  assign hazard   = same_set;
  assign cur_bits = plru_t'(lru_dout0);
`endif

  assign req_ready = ~s1_valid_q | (resp_ready & ~hazard);
  assign accept    = req_valid & req_ready;

  plru_next u_plru_next (
    .cur_bits (cur_bits),
    .hit      (req_hit),
    .hit_way  (way_t'(req_way)),
    .way      (s0_way),
    .new_bits (new_bits)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_set_d   = s1_set_q;
    s1_way_d   = s1_way_q;
    s1_bits_d  = s1_bits_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_set_d   = req_set;
      s1_way_d   = s0_way;
      s1_bits_d  = new_bits;
    end else if (fire) begin
      s1_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_set_q   <= '0;
      s1_way_q   <= '0;
      s1_bits_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_set_q   <= s1_set_d;
      s1_way_q   <= s1_way_d;
      s1_bits_q  <= s1_bits_d;
    end
  end

  assign resp_valid = s1_valid_q;
  assign resp_way   = s1_way_q;

  assign lru_csb0  = ~req_valid;
  assign lru_web0  = 1'b1;
  assign lru_addr0 = req_set;

  // Write-back happens only when the response is consumed: one write per accept.
  assign lru_csb1  = ~fire;
  assign lru_web1  = ~fire;
  assign lru_addr1 = s1_set_q;
  assign lru_din1  = s1_bits_q;
endmodule

// File: tb/tb_lru_update_ctrl.sv
// Scoreboard bench for lru_update_ctrl with a behavioural LRU array (S_INDEX=4).
// Driver pushes hand-computed {set, bits, way}; a negedge monitor checks responses and writes.
module tb_lru_update_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0, req_ready, req_hit = 1'b0;
  logic [3:0] req_set = '0;
  logic [1:0] req_way = '0;
  logic       resp_valid, resp_ready = 1'b1;
  logic [1:0] resp_way;
  logic       lru_csb0, lru_web0, lru_csb1, lru_web1;
  logic [3:0] lru_addr0, lru_addr1;
  logic [2:0] lru_dout0, lru_din1;

  logic [2:0] mem   [16];
  logic [2:0] model [16];
  logic [8:0] sb [$];
  int checks = 0, failures = 0, accepts = 0, writes = 0;
  bit rand_mode = 1'b0;

  always #5 clk = ~clk;

  lru_update_ctrl #(.S_INDEX(4), .WIDTH(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_set(req_set),
    .req_hit(req_hit), .req_way(req_way),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_way(resp_way),
    .lru_csb0(lru_csb0), .lru_web0(lru_web0), .lru_addr0(lru_addr0), .lru_dout0(lru_dout0),
    .lru_csb1(lru_csb1), .lru_web1(lru_web1), .lru_addr1(lru_addr1), .lru_din1(lru_din1)
  );

  // Array: combinational read port 0, write port 1, synchronous clear under reset.
  assign lru_dout0 = mem[lru_addr0];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else if (!lru_csb1 && !lru_web1) begin
      mem[lru_addr1] <= lru_din1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_victim(input logic [2:0] b);
    case (b)
      3'b000, 3'b100: return 2'd0;
      3'b010, 3'b110: return 2'd1;
      3'b001, 3'b011: return 2'd2;
      default:        return 2'd3;
    endcase
  endfunction

  function automatic logic [2:0] ref_touch(input logic [2:0] b, input logic [1:0] w);
    case (w)
      2'd0: return {b[2], 2'b11};
      2'd1: return {b[2], 2'b01};
      2'd2: return {1'b1, b[1], 1'b0};
      default: return {1'b0, b[1], 1'b0};
    endcase
  endfunction

  // Monitor: every fire must match the oldest expected entry and write it; otherwise no write.
  always @(negedge clk) begin
    if (rst_n) begin
      if (resp_valid && resp_ready) begin
        writes++;
        if (sb.size() == 0) begin
          chk("resp_unexpected", 1, 0);
        end else begin
          logic [8:0] e;
          e = sb.pop_front();
          chk("resp_way", {30'd0, resp_way}, {30'd0, e[1:0]});
          chk("wr_en", {30'd0, lru_csb1, lru_web1}, 32'd0);
          chk("wr_addr", {28'd0, lru_addr1}, {28'd0, e[8:5]});
          chk("wr_data", {29'd0, lru_din1}, {29'd0, e[4:2]});
        end
      end else begin
        chk("no_write", {30'd0, lru_csb1, lru_web1}, 32'd3);
      end
    end
  end

  task automatic issue(input logic [3:0] s, input logic h, input logic [1:0] w,
                       input logic [1:0] ew, input logic [2:0] eb, output int stalls);
    bit ok;
    ok = 1'b0;
    stalls = 0;
    req_valid = 1'b1; req_set = s; req_hit = h; req_way = w;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (req_ready) begin
        sb.push_back({s, eb, ew});
        model[s] = eb;
        accepts++;
        ok = 1'b1;
        break;
      end
      stalls++;
      @(posedge clk); #1;
      if (rand_mode) resp_ready = 1'($urandom_range(0, 1));
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (rand_mode) resp_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic issue_model(input logic [3:0] s, input logic h, input logic [1:0] w, output int stalls);
    logic [1:0] ew;
    ew = h ? w : ref_victim(model[s]);
    issue(s, h, w, ew, ref_touch(model[s], ew), stalls);
  endtask

  initial begin
    int st, tot;
    logic [1:0] held;
    for (int i = 0; i < 16; i++) model[i] = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_resp_valid", {31'd0, resp_valid}, 0);
    chk("rst_req_ready", {31'd0, req_ready}, 1);
    chk("rst_resp_way", {30'd0, resp_way}, 0);
    chk("rst_ports", {28'd0, lru_csb0, lru_web0, lru_csb1, lru_web1}, 32'hF);
    @(posedge clk); #1;

    // 1: two misses on set 5
    issue(4'd5, 1'b0, 2'd0, 2'd0, 3'b011, st);
    issue(4'd5, 1'b0, 2'd0, 2'd2, 3'b110, st);

    // 2: hits on set 3, ways 0..3, then a miss
    tot = 0;
    issue(4'd3, 1'b1, 2'd0, 2'd0, 3'b011, st); tot += st;
    issue(4'd3, 1'b1, 2'd1, 2'd1, 3'b001, st); tot += st;
    issue(4'd3, 1'b1, 2'd2, 2'd2, 3'b100, st); tot += st;
    issue(4'd3, 1'b1, 2'd3, 2'd3, 3'b000, st); tot += st;
`ifdef LRU_FWD_EN
    chk("hits_stalls", tot, 0);
`else
    chk("hits_stalls", tot, 3);
`endif
    issue(4'd3, 1'b0, 2'd2, 2'd0, 3'b011, st);

    // 3: back-to-back misses on set 7
    issue(4'd7, 1'b0, 2'd0, 2'd0, 3'b011, st);
    issue(4'd7, 1'b0, 2'd0, 2'd2, 3'b110, st);
`ifdef LRU_FWD_EN
    chk("b2b_stall", st, 0);
`else
    chk("b2b_stall", st, 1);
`endif
    repeat (2) @(posedge clk); #1;
    chk("mem5", {29'd0, mem[5]}, {29'd0, 3'b110});
    chk("mem3", {29'd0, mem[3]}, {29'd0, 3'b011});
    chk("mem7", {29'd0, mem[7]}, {29'd0, 3'b110});

    // 4: back-pressure on set 1
    resp_ready = 1'b0;
    issue(4'd1, 1'b0, 2'd0, 2'd0, 3'b011, st);
    held = resp_way;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", {31'd0, resp_valid}, 1);
      chk("bp_way", {30'd0, resp_way}, {30'd0, held});
      chk("bp_req_ready", {31'd0, req_ready}, 0);
      chk("bp_web1", {31'd0, lru_web1}, 1);
    end
    @(posedge clk); #1 resp_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("mem1", {29'd0, mem[1]}, {29'd0, 3'b011});

    // 5: reset with a pending response held
    resp_ready = 1'b0;
    issue(4'd9, 1'b0, 2'd0, 2'd0, 3'b011, st);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_resp_valid", {31'd0, resp_valid}, 0);
    chk("arst_wr", {30'd0, lru_csb1, lru_web1}, 32'd3);
    sb.delete();
    for (int i = 0; i < 16; i++) model[i] = '0;
    accepts = 0; writes = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    resp_ready = 1'b1;
    chk("arst_mem9", {29'd0, mem[9]}, 0);
    @(posedge clk); #1;
    issue(4'd9, 1'b0, 2'd0, 2'd0, 3'b011, st);

    // 6: random traffic over a few sets against the reference model
    rand_mode = 1'b1;
    for (int i = 0; i < 400; i++)
      issue_model(4'($urandom_range(0, 3) + (i[0] ? 4'd12 : 4'd0)), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), st);
    rand_mode = 1'b0;
    resp_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    for (int i = 0; i < 16; i++) chk($sformatf("final_mem%0d", i), {29'd0, mem[i]}, {29'd0, model[i]});
    chk("writes_eq_accepts", writes, accepts);
    chk("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
